fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
// - Program-counter/fetch stage feeding decode and the ALU of the 8-bit core.
// - Drives the synchronous instruction ROM and presents one instruction per cycle.
// - Consumes the ALU branch outcome (branch_pc) and its result byte (rslt = signed branch offset).
// - Holds PC on stall; stops on halt and reports done.
// PARAMETERS
// - PC_W        10     program-counter / ROM address width
// - INSTR_W     9      instruction width
// - START_ADDR  0      PC loaded on start
// - CNT_W       16     retired-instruction counter width
// PORTS
// - clk            in   1        single clock, all state on rising edge
// - rst_n          in   1        asynchronous, active-low reset
// - start          in   1        begin execution (honoured in IDLE/HALTED only)
// - stall          in   1        freeze fetch/execute this cycle
// - branch_pc      in   1        ALU branch-taken for the instruction on instr
// - branch_off     in   8        ALU rslt: signed PC-relative offset
// - halt_req       in   1        decode flags instruction on instr as HALT
// - imem_addr      out  PC_W     ROM address (= fetch_pc)
// - imem_en        out  1        ROM read enable; ROM holds its output when low
// - imem_data      in   INSTR_W  ROM data, 1-cycle latency after addr+en
// - instr          out  INSTR_W  = imem_data (combinational pass-through)
// - instr_valid    out  1        instr is a live instruction
// - pc             out  PC_W     PC of instr (exec_pc)
// - done           out  1        program halted
// - retired        out  CNT_W    instructions retired since start, saturating
// BEHAVIOUR
// - States: IDLE, RUN, HALTED.
// - Reset (async, any time): state=IDLE; fetch_pc=exec_pc=0; instr_valid=0;
//   done=0; retired=0. imem_en=0 in reset and in IDLE.
// - imem_en = (state==RUN) && !stall.
// - IDLE/HALTED + start: fetch_pc=START_ADDR; instr_valid=0; retired=0;
//   done=0; state=RUN. First valid instr appears 2 cycles after start.
// - start while RUN: ignored.
// - RUN, priority order per cycle:
//   1. stall=1: every register holds. branch_pc/halt_req ignored; re-sampled next cycle.
//   2. instr_valid & halt_req: state=HALTED; done=1; instr_valid=0; retired+1.
//      Halt beats branch.
//   3. instr_valid & branch_pc: fetch_pc = exec_pc + sext(branch_off), mod 2^PC_W.
//      instr_valid=0 (one-bubble flush of the in-flight fetch); retired+1.
//   4. Otherwise: exec_pc=fetch_pc; fetch_pc=fetch_pc+1 (wraps 2^PC_W-1 -> 0);
//      instr_valid=1. retired+1 if the old instr_valid=1.
// - Branch/halt inputs are qualified by instr_valid. Ignore them during bubbles.
// - retired saturates at 2^CNT_W-1.
// - HALTED: done held 1, PC frozen, imem_en=0, until start or reset.
// - Offset is 8-bit two's complement sign-extended to PC_W. Result wraps; no error flag.
// STRUCTURE
// - fetch_pkg: state_t enum {IDLE,RUN,HALTED}; PC_W/INSTR_W defaults;
//   function sext_off(8b)->PC_W.
// - One sub-module, fetch_next_pc (combinational): takes fetch_pc, exec_pc,
//   branch_off and the branch-taken select, and returns next fetch_pc.
// - FSM and registers in fetch_unit. Async-reset always_ff.
// TESTING
// - Reset then start, ROM[i]=i, no stall
//   -> imem_addr 0,1,2,...; instr_valid rises on cycle 2; pc=0,1,2.
// - Branch at pc=5 with branch_off=8'hFD (-3)
//   -> one cycle instr_valid=0; next imem_addr=2; pc=2 two cycles later.
// - Wrap: branch at pc=1 with off=-4 -> fetch 1021. Sequential run from 1023 -> fetch 0.
// - stall held 3 cycles mid-run with branch_pc=1 asserted
//   -> pc/instr/imem_addr frozen, imem_en=0, no redirect until stall drops.
// - halt_req and branch_pc together at pc=7 -> HALTED, done=1, retired=8, no redirect.
//   start -> restart at 0, done=0, retired=0.
// - rst_n low mid-RUN (asynchronous, between edges)
//   -> outputs zero immediately; IDLE; start again works normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the 8-bit core's fetch stage.
package fetch_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Branch offsets arrive as an 8-bit two's-complement ALU result.
    function automatic logic signed [PC_W-1:0] sext_off(input logic signed [7:0] off);
        logic signed [PC_W-1:0] ext;
        ext = off;
        return ext;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-ROM bus between the fetch stage and a synchronous ROM.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
);
    logic [PC_W-1:0]    imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_addr, output imem_en, input  imem_data);
    modport slave  (input  imem_addr, input  imem_en, output imem_data);
endinterface

// File: rtl/fetch_next_pc.sv
// Next fetch address: sequential increment or exec_pc-relative branch target.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int PC_W = fetch_pkg::PC_W
) (
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic [PC_W-1:0]  exec_pc,
    input  logic signed [7:0] branch_off,
    input  logic             take_branch,
    output logic [PC_W-1:0]  next_pc
);
    logic signed [PC_W-1:0] off_ext;

    assign off_ext = PC_W'(sext_off(branch_off));
    // Both paths wrap modulo 2^PC_W; no overflow is reported.
    assign next_pc = take_branch ? (exec_pc + off_ext) : (fetch_pc + PC_W'(1));
endmodule

// File: rtl/fetch_unit.sv
// Program-counter / fetch stage: drives the instruction ROM, tracks the PC of
// the live instruction, handles stall, branch redirect and halt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = fetch_pkg::PC_W,
    parameter int              INSTR_W    = fetch_pkg::INSTR_W,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_pc,
    input  logic signed [7:0]  branch_off,
    input  logic               halt_req,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);
    state_t            state, state_nxt;
    logic [PC_W-1:0]   fetch_pc, fetch_pc_nxt;
    logic [PC_W-1:0]   exec_pc, exec_pc_nxt;
    logic [PC_W-1:0]   next_pc;
    logic              valid_nxt, done_nxt, take_branch;
    logic [CNT_W-1:0]  retired_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Halt outranks branch, so the redirect select must exclude it.
    assign take_branch = instr_valid & branch_pc & ~halt_req;

    fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
        .fetch_pc    (fetch_pc),
        .exec_pc     (exec_pc),
        .branch_off  (branch_off),
        .take_branch (take_branch),
        .next_pc     (next_pc)
    );

    assign imem.imem_addr = fetch_pc;
    assign imem.imem_en   = (state == RUN) && !stall;
    assign instr          = imem.imem_data;
    assign pc             = exec_pc;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        exec_pc_nxt  = exec_pc;
        valid_nxt    = instr_valid;
        done_nxt     = done;
        retired_nxt  = retired;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt    = RUN;
                    fetch_pc_nxt = START_ADDR;
                    valid_nxt    = 1'b0;
                    done_nxt     = 1'b0;
                    retired_nxt  = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (instr_valid && halt_req) begin
                        state_nxt   = HALTED;
                        done_nxt    = 1'b1;
                        valid_nxt   = 1'b0;
                        retired_nxt = sat_inc(retired);
                    end else if (instr_valid && branch_pc) begin
                        // The fetch already in flight is wrong-path: drop it as a bubble.
                        fetch_pc_nxt = next_pc;
                        valid_nxt    = 1'b0;
                        retired_nxt  = sat_inc(retired);
                    end else begin
                        exec_pc_nxt  = fetch_pc;
                        fetch_pc_nxt = next_pc;
                        valid_nxt    = 1'b1;
                        if (instr_valid) retired_nxt = sat_inc(retired);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= '0;
            exec_pc     <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            retired     <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            exec_pc     <= exec_pc_nxt;
            instr_valid <= valid_nxt;
            done        <= done_nxt;
            retired     <= retired_nxt;
        end
    end
endmodule
